// File: rtl/dac_dual_serializer_if.sv
// Sample-pair handshake between the CORDIC result stage and the DAC serializer.
// Upstream drives a pair plus valid; the serializer answers with ready.
interface dac_dual_serializer_if;
    logic [11:0] ch1_data;
    logic [11:0] ch2_data;
    logic        in_valid;
    logic        in_ready;

    modport master (
        output ch1_data,
        output ch2_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  ch1_data,
        input  ch2_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/dac_dual_serializer.sv
// Dual DAC121S101 serial driver: one sample pair per 16-bit frame on shared
// SCLK/NSYNC, MSB first, with an NSYNC-high gap after every frame.
module dac_dual_serializer #(
    parameter int CLK_DIV       = 2,
    parameter int GAP_CYCLES    = 4,
    parameter int OFFSET_BINARY = 1
) (
    input  logic clk,
    input  logic rst,
    dac_dual_serializer_if.slave smp,
    output logic SCLK,
    output logic NSYNC,
    output logic SDATA1,
    output logic SDATA2,
    output logic frame_done
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic OB = (OFFSET_BINARY != 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_cnt_n;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic [4:0]    bit_cnt, bit_cnt_n;
    logic [15:0]   sr1, sr1_n, sr2, sr2_n;
    logic          rdy, rdy_n;
    logic          sclk_n, nsync_n, sd1_n, sd2_n, done_n;
    logic [15:0]   w1, w2;

    // The pair is captured only here, so later input changes cannot touch the frame.
    assign w1 = {4'b0000, smp.ch1_data[11] ^ OB, smp.ch1_data[10:0]};
    assign w2 = {4'b0000, smp.ch2_data[11] ^ OB, smp.ch2_data[10:0]};
    assign smp.in_ready = rdy;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_n   = state;
        div_cnt_n = div_cnt;
        gap_cnt_n = gap_cnt;
        bit_cnt_n = bit_cnt;
        sr1_n     = sr1;
        sr2_n     = sr2;
        rdy_n     = rdy;
        sclk_n    = SCLK;
        nsync_n   = NSYNC;
        sd1_n     = SDATA1;
        sd2_n     = SDATA2;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                rdy_n   = 1'b1;
                nsync_n = 1'b1;
                sclk_n  = 1'b1;
                sd1_n   = 1'b0;
                sd2_n   = 1'b0;
                if (smp.in_valid && rdy) begin
                    state_n   = SHIFT;
                    rdy_n     = 1'b0;
                    nsync_n   = 1'b0;
                    sr1_n     = w1;
                    sr2_n     = w2;
                    sd1_n     = w1[15];
                    sd2_n     = w2[15];
                    div_cnt_n = '0;
                    bit_cnt_n = '0;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (SCLK) begin
                        // Falling edge: the DAC samples the current bit here.
                        sclk_n    = 1'b0;
                        bit_cnt_n = bit_cnt + 5'd1;
                    end else if (bit_cnt == 5'd16) begin
                        state_n   = GAP;
                        sclk_n    = 1'b1;
                        nsync_n   = 1'b1;
                        sd1_n     = 1'b0;
                        sd2_n     = 1'b0;
                        done_n    = 1'b1;
                        gap_cnt_n = '0;
                    end else begin
                        // Rising edge: advance to the next bit.
                        sclk_n = 1'b1;
                        sr1_n  = {sr1[14:0], 1'b0};
                        sr2_n  = {sr2[14:0], 1'b0};
                        sd1_n  = sr1[14];
                        sd2_n  = sr2[14];
                    end
                end else begin
                    div_cnt_n = div_cnt + DW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    rdy_n   = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            gap_cnt    <= '0;
            bit_cnt    <= '0;
            sr1        <= '0;
            sr2        <= '0;
            rdy        <= 1'b0;
            SCLK       <= 1'b1;
            NSYNC      <= 1'b1;
            SDATA1     <= 1'b0;
            SDATA2     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            gap_cnt    <= gap_cnt_n;
            bit_cnt    <= bit_cnt_n;
            sr1        <= sr1_n;
            sr2        <= sr2_n;
            rdy        <= rdy_n;
            SCLK       <= sclk_n;
            NSYNC      <= nsync_n;
            SDATA1     <= sd1_n;
            SDATA2     <= sd2_n;
            frame_done <= done_n;
        end
    end
endmodule

// File: tb/tb_dac_dual_serializer.sv
// Directed bench for dac_dual_serializer: three instances cover the default,
// offset-binary and fastest-clock configurations.
module tb_dac_dual_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_dual_serializer_if bus0 ();
    dac_dual_serializer_if bus1 ();
    dac_dual_serializer_if bus2 ();

    logic sc0, ns0, a0, b0, fd0;
    logic sc1, ns1, a1, b1, fd1;
    logic sc2, ns2, a2, b2, fd2;

    dac_dual_serializer #(.CLK_DIV(2), .GAP_CYCLES(4), .OFFSET_BINARY(0)) dut0 (
        .clk(clk), .rst(rst), .smp(bus0.slave), .SCLK(sc0), .NSYNC(ns0),
        .SDATA1(a0), .SDATA2(b0), .frame_done(fd0));
    dac_dual_serializer #(.CLK_DIV(2), .GAP_CYCLES(4), .OFFSET_BINARY(1)) dut1 (
        .clk(clk), .rst(rst), .smp(bus1.slave), .SCLK(sc1), .NSYNC(ns1),
        .SDATA1(a1), .SDATA2(b1), .frame_done(fd1));
    dac_dual_serializer #(.CLK_DIV(1), .GAP_CYCLES(1), .OFFSET_BINARY(0)) dut2 (
        .clk(clk), .rst(rst), .smp(bus2.slave), .SCLK(sc2), .NSYNC(ns2),
        .SDATA1(a2), .SDATA2(b2), .frame_done(fd2));

    int checks = 0;
    int failures = 0;

    int acc_t [4];
    int lowlen [4];
    int falls_f [4];
    int gap_f [4];
    logic [15:0] cap1 [4];
    logic [15:0] cap2 [4];
    int hi_min, fdcnt, rdy_ret, nontog;
    bit done_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [11:0] x, input logic [11:0] y, input logic v);
        case (d)
            0: begin bus0.ch1_data = x; bus0.ch2_data = y; bus0.in_valid = v; end
            1: begin bus1.ch1_data = x; bus1.ch2_data = y; bus1.in_valid = v; end
            default: begin bus2.ch1_data = x; bus2.ch2_data = y; bus2.in_valid = v; end
        endcase
    endtask

    task automatic samp(input int d, output logic ns, output logic sc, output logic d1,
                        output logic d2, output logic fd, output logic rd);
        case (d)
            0: begin ns = ns0; sc = sc0; d1 = a0; d2 = b0; fd = fd0; rd = bus0.in_ready; end
            1: begin ns = ns1; sc = sc1; d1 = a1; d2 = b1; fd = fd1; rd = bus1.in_ready; end
            default: begin ns = ns2; sc = sc2; d1 = a2; d2 = b2; fd = fd2; rd = bus2.in_ready; end
        endcase
    endtask

    // Send n pairs with in_valid held high, changing data only after each
    // acceptance, and decode every frame at the SCLK falling edges.
    task automatic stream(input int d, input int n,
                          input logic [11:0] x0, input logic [11:0] y0,
                          input logic [11:0] x1, input logic [11:0] y1,
                          input logic [11:0] x2, input logic [11:0] y2);
        logic [11:0] xa [3];
        logic [11:0] ya [3];
        logic [15:0] s1, s2;
        logic ns, sc, d1, d2, fd, rd, pns, psc, jacc, valid;
        int idx, f, cyc, lowc, fc, hic;
        xa[0] = x0; xa[1] = x1; xa[2] = x2;
        ya[0] = y0; ya[1] = y1; ya[2] = y2;
        idx = 0; f = 0; cyc = 0; lowc = 0; fc = 0; hic = 0;
        s1 = '0; s2 = '0; pns = 1'b1; psc = 1'b1; jacc = 1'b0;
        fdcnt = 0; hi_min = 1000; nontog = 0; rdy_ret = -1; done_ok = 0;
        @(negedge clk);
        drive(d, xa[0], ya[0], 1'b1);
        valid = 1'b1;
        while (!done_ok && cyc < 1000) begin
            samp(d, ns, sc, d1, d2, fd, rd);
            if (fd) fdcnt++;
            if (!ns) begin
                lowc++;
                if (!pns && sc == psc) nontog++;
                if (psc && !sc) begin
                    s1 = {s1[14:0], d1};
                    s2 = {s2[14:0], d2};
                    fc++;
                end
                if (pns && f > 0 && hic < hi_min) hi_min = hic;
            end else begin
                if (!pns) begin
                    lowlen[f] = lowc; cap1[f] = s1; cap2[f] = s2;
                    falls_f[f] = fc; gap_f[f] = 0; f++;
                    lowc = 0; fc = 0; s1 = '0; s2 = '0; hic = 0;
                end
                hic++;
                if (f > 0 && !rd) gap_f[f-1]++;
            end
            if (valid && rd) begin
                acc_t[idx] = cyc;
                idx++;
                jacc = 1'b1;
            end
            if (f == n && idx == n && rd) begin
                rdy_ret = cyc - acc_t[n-1];
                done_ok = 1;
            end
            pns = ns;
            psc = sc;
            if (!done_ok) begin
                @(negedge clk);
                cyc++;
                if (jacc) begin
                    jacc = 1'b0;
                    if (idx < n) drive(d, xa[idx], ya[idx], 1'b1);
                    else begin
                        drive(d, 12'h000, 12'h000, 1'b0);
                        valid = 1'b0;
                    end
                end
            end
        end
        chk("stream_complete", 32'(done_ok), 32'd1);
    endtask

    logic ns, sc, d1, d2, fd, rd;
    int falls, guard, fds;

    initial begin
        drive(0, 12'h000, 12'h000, 1'b0);
        drive(1, 12'h000, 12'h000, 1'b0);
        drive(2, 12'h000, 12'h000, 1'b0);

        // Reset held three cycles with in_valid high on dut0.
        rst = 1'b1;
        drive(0, 12'hFFF, 12'hFFF, 1'b1);
        repeat (3) @(negedge clk);
        samp(0, ns, sc, d1, d2, fd, rd);
        chk("rst_nsync", 32'(ns), 32'd1);
        chk("rst_sclk", 32'(sc), 32'd1);
        chk("rst_sdata", {30'd0, d1, d2}, 32'd0);
        chk("rst_in_ready", 32'(rd), 32'd0);
        chk("rst_frame_done", 32'(fd), 32'd0);
        drive(0, 12'h000, 12'h000, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        samp(0, ns, sc, d1, d2, fd, rd);
        chk("rel_in_ready0", 32'(rd), 32'd1);
        chk("rel_in_ready2", 32'(bus2.in_ready), 32'd1);

        // Single frame, plain two's complement pass-through.
        stream(0, 1, 12'hA5C, 12'h3F0, 12'h0, 12'h0, 12'h0, 12'h0);
        chk("single_low", 32'(lowlen[0]), 32'd64);
        chk("single_falls", 32'(falls_f[0]), 32'd16);
        chk("single_ch1", 32'(cap1[0]), 32'h0A5C);
        chk("single_ch2", 32'(cap2[0]), 32'h03F0);
        chk("single_done", 32'(fdcnt), 32'd1);
        chk("single_ready", 32'(rdy_ret), 32'd69);
        chk("single_gap", 32'(gap_f[0]), 32'd4);

        // Offset binary conversion at the code extremes.
        stream(1, 1, 12'h800, 12'h7FF, 12'h0, 12'h0, 12'h0, 12'h0);
        chk("ob_800", 32'(cap1[0]), 32'h0000);
        chk("ob_7ff", 32'(cap2[0]), 32'h0FFF);
        stream(1, 1, 12'h000, 12'hFFF, 12'h0, 12'h0, 12'h0, 12'h0);
        chk("ob_000", 32'(cap1[0]), 32'h0800);
        chk("ob_fff", 32'(cap2[0]), 32'h07FF);

        // Back-to-back frames under continuous in_valid.
        stream(0, 3, 12'h111, 12'h222, 12'hABC, 12'hDEF, 12'hFFF, 12'h001);
        chk("b2b_period01", 32'(acc_t[1] - acc_t[0]), 32'd69);
        chk("b2b_period12", 32'(acc_t[2] - acc_t[1]), 32'd69);
        chk("b2b_gap_min", 32'(hi_min >= 4), 32'd1);
        chk("b2b_f0", {cap1[0], cap2[0]}, 32'h0111_0222);
        chk("b2b_f1", {cap1[1], cap2[1]}, 32'h0ABC_0DEF);
        chk("b2b_f2", {cap1[2], cap2[2]}, 32'h0FFF_0001);
        chk("b2b_done", 32'(fdcnt), 32'd3);

        // Reset after the 7th falling edge aborts the frame.
        @(negedge clk);
        drive(0, 12'h456, 12'h789, 1'b1);
        guard = 0;
        do begin
            samp(0, ns, sc, d1, d2, fd, rd);
            @(negedge clk);
            guard++;
        end while (!rd && guard < 200);
        drive(0, 12'h000, 12'h000, 1'b0);
        falls = 0;
        fds = 0;
        guard = 0;
        sc = 1'b1;
        while (falls < 7 && guard < 200) begin
            d1 = sc;
            samp(0, ns, sc, d2, d2, fd, rd);
            if (fd) fds++;
            if (!ns && d1 && !sc) falls++;
            if (falls < 7) begin
                @(negedge clk);
                guard++;
            end
        end
        chk("abort_reached_fall7", 32'(falls), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        samp(0, ns, sc, d1, d2, fd, rd);
        if (fd) fds++;
        chk("abort_nsync", 32'(ns), 32'd1);
        chk("abort_sclk", 32'(sc), 32'd1);
        repeat (2) begin
            @(negedge clk);
            samp(0, ns, sc, d1, d2, fd, rd);
            if (fd) fds++;
        end
        rst = 1'b0;
        @(negedge clk);
        samp(0, ns, sc, d1, d2, fd, rd);
        if (fd) fds++;
        chk("abort_no_done", 32'(fds), 32'd0);
        chk("abort_ready", 32'(rd), 32'd1);
        stream(0, 1, 12'h123, 12'h000, 12'h0, 12'h0, 12'h0, 12'h0);
        chk("after_abort_ch1", 32'(cap1[0]), 32'h0123);

        // Fastest configuration: CLK_DIV=1, GAP_CYCLES=1.
        stream(2, 2, 12'h5A5, 12'h0F0, 12'h3C3, 12'hC3C, 12'h0, 12'h0);
        chk("fast_low", 32'(lowlen[0]), 32'd32);
        chk("fast_sclk_div2", 32'(nontog), 32'd0);
        chk("fast_gap", 32'(gap_f[0]), 32'd1);
        chk("fast_period", 32'(acc_t[1] - acc_t[0]), 32'd34);
        chk("fast_f0", {cap1[0], cap2[0]}, 32'h05A5_00F0);
        chk("fast_f1", {cap1[1], cap2[1]}, 32'h03C3_0C3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dac_dual_serializer.md
# dac_dual_serializer

Dual-channel serial driver for a pair of 12-bit DAC121S101-class converters on a shared SCLK/NSYNC bus (PmodDA2 style). It sits directly downstream of the CORDIC result stage in the tan/DAC top. It accepts one pair of 12-bit samples per frame through a valid/ready handshake and optionally converts them from two's complement to offset binary. It then shifts both channels out MSB-first in 16-bit frames, with a guaranteed NSYNC-high gap between frames.

## Interface
- CLK_DIV, 2: clk cycles per SCLK half-period (≥1); SCLK = clk/(2·CLK_DIV)
- GAP_CYCLES, 4: clk cycles NSYNC held high after each frame (≥1)
- OFFSET_BINARY, 1: 1 = invert sample MSB (two's complement → offset binary); 0 = pass through
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- ch1_data  in  12  channel-1 sample
- ch2_data  in  12  channel-2 sample
- in_valid  in  1  sample pair valid
- in_ready  out  1  block can accept a pair (IDLE only)
- SCLK  out  1  serial clock, idles high
- NSYNC  out  1  frame sync, active low
- SDATA1  out  1  channel-1 serial data
- SDATA2  out  1  channel-2 serial data
- frame_done  out  1  one-cycle pulse at end of each completed frame

## Operation
- All outputs are registered. Reset values: NSYNC=1, SCLK=1, SDATA1=SDATA2=0, in_ready=0, frame_done=0, state=IDLE, counters=0.
- Frame word per channel: {2'b00, PD1=0, PD0=0, data[11:0]}, sent MSB first. When OFFSET_BINARY=1, data[11] is inverted before load.
- States:
  - IDLE: in_ready=1, NSYNC=1, SCLK=1. A transfer occurs when in_valid & in_ready; both 16-bit shift registers load, and the state moves to SHIFT.
  - SHIFT: NSYNC=0. div_cnt counts 0..CLK_DIV-1; SCLK toggles when div_cnt=CLK_DIV-1. On each SCLK falling edge bit_cnt increments; the DAC samples at these edges. On each SCLK rising edge both shift registers shift left and SDATA presents the next bit. When the rising edge after the 16th falling edge is reached, go to GAP and pulse frame_done.
  - GAP: NSYNC=1, SCLK=1, SDATA=0. Hold for GAP_CYCLES, then go to IDLE.
- SDATA1/SDATA2 carry bit15 of the frame from the first SHIFT cycle. Each bit is stable for the full SCLK period around its falling edge.
- in_valid outside IDLE is ignored; in_ready=0 there. The upstream stage must hold data until accepted. Input changes during a frame do not affect the frame in flight.
- rst mid-frame aborts immediately: next edge restores reset values. The partial frame is discarded, because NSYNC rises before the 16th falling edge and the DAC ignores it. No frame_done is emitted.
- rst has priority over a simultaneous in_valid.

## Timing
- Acceptance at edge T0 (in_valid & in_ready sampled high): NSYNC low from T0+1 for exactly 32·CLK_DIV cycles.
- Falling edges of SCLK occur at T0+1+CLK_DIV·(2k+1), k=0..15.
- frame_done is high the cycle NSYNC returns high. in_ready returns to 1 after GAP_CYCLES cycles of GAP.
- Frame period with in_valid held high: 1 + 32·CLK_DIV + GAP_CYCLES cycles. This is 69 with defaults.
- in_ready deasserts the cycle after acceptance; there is no combinational path from in_valid to any output.
- First cycle after rst deasserts: in_ready=1.

## Test plan
- Reset: hold rst 3 cycles mid-anything. Required: NSYNC=1, SCLK=1, SDATA1/2=0, in_ready=0, frame_done=0; in_ready=1 the cycle after release.
- Single frame, defaults with OFFSET_BINARY=0, ch1=12'hA5C, ch2=12'h3F0. Required: NSYNC low exactly 64 cycles, exactly 16 SCLK falling edges, and bits captured at falling edges = 16'h0A5C / 16'h03F0. Also one frame_done pulse, and in_ready high again 69 cycles after acceptance.
- Offset binary, OFFSET_BINARY=1. Inputs ch1=12'h800, ch2=12'h7FF must yield 16'h0000 / 16'h0FFF. Inputs ch1=12'h000, ch2=12'hFFF must yield 16'h0800 / 16'h07FF.
- Back-to-back: in_valid held high with 3 distinct pairs, data changed only on acceptance. Required: acceptances exactly 69 cycles apart, NSYNC high ≥4 cycles between frames, and every frame decodes correctly.
- Reset after the 7th falling edge of a frame. Required: NSYNC=1 and SCLK=1 on the next cycle and no frame_done; a following frame with ch1=12'h123 decodes as 16'h0123.
- CLK_DIV=1, GAP_CYCLES=1. Required: SCLK = clk/2, NSYNC low 32 cycles, NSYNC high 1 cycle in GAP, and a 34-cycle frame period under continuous in_valid.
